// File: rtl/pwc_pkg.sv
// Shared types and frame layout for the pulse-width measurement sequencer.
// Frame length follows the PWC_CHECKSUM_EN build macro.
package pwc_pkg;

  typedef enum logic [1:0] {IDLE, ARMED, SEND} state_t;

  localparam logic [3:0]  HDR_MAGIC   = 4'hA;
  localparam int unsigned HDR_TO_BIT  = 0;
  localparam int unsigned HDR_OVR_BIT = 1;

`ifdef PWC_CHECKSUM_EN
  localparam int unsigned FRAME_LEN = 5;
`else
  localparam int unsigned FRAME_LEN = 4;
`endif

  localparam int unsigned IDX_W = $clog2(FRAME_LEN);
  typedef logic [IDX_W-1:0] idx_t;

endpackage

// File: rtl/pwc_watchdog.sv
// No-signal watchdog: counts enabled cycles since the last clear and strobes
// timeout on the cycle the count reaches TIMEOUT_CYCLES-1 without a clear.
module pwc_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic timeout
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign timeout = enable && !clear && (count == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/pulse_measure_sequencer.sv
// Arms pulse-width measurements, decimates PULSE strobes, watches for loss of
// signal and streams each snapshot as a byte frame. Build macro: PWC_CHECKSUM_EN.
module pulse_measure_sequencer
  import pwc_pkg::*;
#(
  parameter int unsigned COUNTER_BITS   = 8,
  parameter int unsigned TIMEOUT_CYCLES = 65535,
  parameter int unsigned DECIM_BITS     = 4
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    START,
  input  logic                    STOP,
  input  logic                    CONT_MODE,
  input  logic [DECIM_BITS-1:0]   DECIM,
  input  logic                    PULSE,
  input  logic [COUNTER_BITS-1:0] TIME_HIGH,
  input  logic [COUNTER_BITS-1:0] TIME_LOW,
  input  logic [COUNTER_BITS-1:0] PERIOD,
  output logic [7:0]              OUT_DATA,
  output logic                    OUT_VALID,
  input  logic                    OUT_READY,
  output logic                    BUSY,
  output logic                    FRAME_DONE
);

  if (COUNTER_BITS != 8) begin : g_bad_counter_bits
    $error("pulse_measure_sequencer: COUNTER_BITS must be 8");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("pulse_measure_sequencer: TIMEOUT_CYCLES must be >= 2");
  end

  state_t state, state_next;

  logic [COUNTER_BITS-1:0] snap_th, snap_tl, snap_p;
  logic                    snap_to, snap_ov;
  logic                    overrun, stop_seen, frame_done;
  logic [DECIM_BITS-1:0]   decim_lat, decim_cnt;
  idx_t                    idx;
  logic                    qualify, wd_timeout, wd_clear, wd_enable;
  logic                    last_xfer, arm_entry, capture;
  logic [7:0]              header;

  assign wd_enable = (state == ARMED);
  assign wd_clear  = PULSE || (state != ARMED);

  pwc_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
    .clk     (CLK),
    .rst_n   (RST_N),
    .clear   (wd_clear),
    .enable  (wd_enable),
    .timeout (wd_timeout)
  );

  assign qualify   = (state == ARMED) && !STOP && PULSE && (decim_cnt == decim_lat);
  assign last_xfer = (state == SEND) && OUT_READY && (idx == idx_t'(FRAME_LEN - 1));

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (START && !STOP) state_next = ARMED;
      ARMED: begin
        if (STOP)                       state_next = IDLE;
        else if (qualify || wd_timeout) state_next = SEND;
      end
      SEND:  if (last_xfer) state_next = (CONT_MODE && !stop_seen && !STOP) ? ARMED : IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign arm_entry = (state_next == ARMED) && (state != ARMED);
  assign capture   = (state == ARMED) && (state_next == SEND);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_next;
  end

  // OVERRUN survives the SEND->ARMED re-arm so it reaches the next header;
  // only a fresh START clears it. The header copy is frozen at capture.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      snap_th    <= '0;
      snap_tl    <= '0;
      snap_p     <= '0;
      snap_to    <= 1'b0;
      snap_ov    <= 1'b0;
      overrun    <= 1'b0;
      stop_seen  <= 1'b0;
      frame_done <= 1'b0;
      decim_lat  <= '0;
      decim_cnt  <= '0;
      idx        <= '0;
    end else begin
      frame_done <= last_xfer;
      if (arm_entry) begin
        decim_cnt <= '0;
        decim_lat <= DECIM;
        if (state == IDLE) overrun <= 1'b0;
      end else if ((state == ARMED) && PULSE) begin
        decim_cnt <= decim_cnt + 1'b1;
      end
      if (capture) begin
        snap_th   <= qualify ? TIME_HIGH : '0;
        snap_tl   <= qualify ? TIME_LOW  : '0;
        snap_p    <= qualify ? PERIOD    : '0;
        snap_to   <= !qualify;
        snap_ov   <= overrun;
        idx       <= '0;
        stop_seen <= 1'b0;
      end
      if (state == SEND) begin
        if (PULSE)     overrun   <= 1'b1;
        if (STOP)      stop_seen <= 1'b1;
        if (OUT_READY) idx       <= idx + 1'b1;
      end
    end
  end

  always_comb begin
    header              = {HDR_MAGIC, 4'b0000};
    header[HDR_OVR_BIT] = snap_ov;
    header[HDR_TO_BIT]  = snap_to;
  end

  always_comb begin
    OUT_DATA = '0;
    if (state == SEND) begin
      case (idx)
        idx_t'(0): OUT_DATA = header;
        idx_t'(1): OUT_DATA = snap_th;
        idx_t'(2): OUT_DATA = snap_tl;
        idx_t'(3): OUT_DATA = snap_p;
`ifdef PWC_CHECKSUM_EN
        idx_t'(4): OUT_DATA = header ^ snap_th ^ snap_tl ^ snap_p;
`endif
        default:   OUT_DATA = '0;
      endcase
    end
  end

  assign OUT_VALID  = (state == SEND);
  assign BUSY       = (state != IDLE);
  assign FRAME_DONE = frame_done;

endmodule
